// File: rtl/req_arbiter8.sv
// 8-way request arbiter with hold-limit timeout; IDLE -> GRANT -> RELEASE -> IDLE.
// Define REQ_ARBITER8_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module req_arbiter8 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam int unsigned CW = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      gnt_q, gnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            vld_q, vld_d;
   logic            to_q, to_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic [2:0]      win_idx;
   logic            found;

`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
   logic [2:0]      rr_ptr_q, rr_ptr_d;
   logic [2:0]      probe;

   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      probe   = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         probe = rr_ptr_q + 3'(k);
         if (!found && req[probe]) begin
            win_idx = probe;
            found   = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (!found && req[k]) begin
            win_idx = 3'(k);
            found   = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      to_d    = 1'b0;
      hold_d  = hold_q;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               gnt_d   = 8'b1 << win_idx;
               idx_d   = win_idx;
               vld_d   = 1'b1;
               // counter restarts at 1 so it already counts the first GRANT cycle
               hold_d  = CW'(1);
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
               rr_ptr_d = win_idx + 3'd1;
`endif
            end
         end
         GRANT: begin
            if (!req[idx_q] || hold_q == CW'(HOLD_MAX)) begin
               state_d = RELEASE;
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               to_d    = req[idx_q];
            end else begin
               hold_d  = hold_q + CW'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
            hold_d  = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
         hold_q  <= '0;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
         hold_q  <= hold_d;
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 with HOLD_MAX=4: per-cycle vector table plus
// hand-written reset and arbitration-order sequences.
module tb_req_arbiter8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   req_arbiter8 #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       to;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g,
                               input logic [2:0] i, input logic v, input logic t);
      vec_t x;
      x.req = r; x.gnt = g; x.idx = i; x.vld = v; x.to = t;
      return x;
   endfunction

   task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et);
      n_tests++;
      if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || timeout !== et) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                  name, gnt, gnt_idx, gnt_vld, timeout, eg, ei, ev, et);
      end
   endtask

   task automatic step(input logic [7:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   // structural invariants on every falling edge
   always @(negedge clk) begin
      n_tests++;
      if ((gnt_vld !== (gnt != 8'h00)) || !$onehot0(gnt) ||
          (gnt_vld && (gnt !== (8'b1 << gnt_idx))) || (!gnt_vld && gnt_idx !== 3'd0)) begin
         n_fail++;
         $display("FAIL invariant: gnt=%b idx=%0d vld=%b", gnt, gnt_idx, gnt_vld);
      end
   end

   initial begin
      logic [2:0] e;

      tbl[0]  = mk(8'h00, 8'h00, 3'd0, 1'b0, 1'b0); // idle, no request
      tbl[1]  = mk(8'hA4, 8'h04, 3'd2, 1'b1, 1'b0); // lowest index wins
      tbl[2]  = mk(8'hA4, 8'h04, 3'd2, 1'b1, 1'b0);
      tbl[3]  = mk(8'hA0, 8'h00, 3'd0, 1'b0, 1'b0); // drop req[2] -> RELEASE
      tbl[4]  = mk(8'hA0, 8'h00, 3'd0, 1'b0, 1'b0); // IDLE
      tbl[5]  = mk(8'hA0, 8'h20, 3'd5, 1'b1, 1'b0); // grant 5
      tbl[6]  = mk(8'hA1, 8'h20, 3'd5, 1'b1, 1'b0); // grant stable vs new req[0]
      tbl[7]  = mk(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      tbl[8]  = mk(8'h08, 8'h00, 3'd0, 1'b0, 1'b0);
      tbl[9]  = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // hold 1
      tbl[10] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // hold 2
      tbl[11] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // hold 3
      tbl[12] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // hold 4
      tbl[13] = mk(8'h08, 8'h00, 3'd0, 1'b0, 1'b1); // timeout
      tbl[14] = mk(8'h08, 8'h00, 3'd0, 1'b0, 1'b0); // IDLE
      tbl[15] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // regrant 3
      tbl[16] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
      tbl[17] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
      tbl[18] = mk(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
      tbl[19] = mk(8'h02, 8'h00, 3'd0, 1'b0, 1'b0); // drop at hold 4: no timeout
      tbl[20] = mk(8'h02, 8'h00, 3'd0, 1'b0, 1'b0);
      tbl[21] = mk(8'h02, 8'h02, 3'd1, 1'b1, 1'b0); // grant 1
      tbl[22] = mk(8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
      tbl[23] = mk(8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
      tbl[24] = mk(8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
      tbl[25] = mk(8'h00, 8'h00, 3'd0, 1'b0, 1'b0); // req[1] drop on hold 4
      tbl[26] = mk(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

      rst_n = 1'b0;
      req   = 8'h00;
      #2;
      check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step(tbl[i].req);
         check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
      end

      // asynchronous reset between edges while granted
      step(8'h10);
      check("pre_rst_grant", 8'h10, 3'd4, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h10);
      check("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      step(8'h00);
      check("post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // all requesting, each grant released after one cycle
      for (int k = 0; k < 9; k++) begin
`ifdef REQ_ARBITER8_ROUND_ROBIN_EN
         e = 3'(k % 8);
`else
         e = 3'd0;
`endif
         step(8'hFF);
         check($sformatf("ff_grant%0d", k), 8'b1 << e, e, 1'b1, 1'b0);
         step(8'hFF & ~(8'b1 << e));
         check($sformatf("ff_release%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
         step(8'hFF);
         check($sformatf("ff_idle%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
